// File: rtl/msf_frame_sequencer.sv
// Assembles MSF decoder seconds into minute frames, validates them and latches the BCD fields.
// Optional B-bit parity checking is enabled by defining MSF_PARITY_CHECK_EN.
module msf_frame_sequencer #(
  parameter int unsigned SAMPLES_PER_SEC = 10,
  parameter int unsigned TIMEOUT_SAMPLES = 15
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       sample_valid_i,
  input  logic       bits_valid_i,
  input  logic       bits_is_second_00_i,
  input  logic [1:0] bits_data_i,
  output logic       sync_o,
  output logic [5:0] second_o,
  output logic       frame_valid_o,
  output logic       frame_error_o,
  output logic [7:0] year_o,
  output logic [4:0] month_o,
  output logic [5:0] day_o,
  output logic [2:0] dow_o,
  output logic [5:0] hour_o,
  output logic [6:0] minute_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_SAMPLES - 1);
  localparam logic [7:0] Marker      = 8'b0111_1110;
  localparam int unsigned unused_samples_per_sec = SAMPLES_PER_SEC;

  typedef enum logic [0:0] {StHunt, StRun} state_t;

  state_t      state_q, state_d;
  logic [5:0]  second_q, second_d;
  logic [42:0] shreg_q, shreg_d;
  logic [7:0]  tcount_q, tcount_d;
  logic [34:0] fields_q, fields_d;
  logic        frame_valid_q, frame_valid_d;
  logic        frame_error_q, frame_error_d;
  logic [5:0]  second_next;
  logic        frame_good;

`ifdef MSF_PARITY_CHECK_EN
  logic [3:0]  par_q, par_d;

  always_comb begin
    frame_good = (second_q == 6'd59) && (shreg_q[7:0] == Marker) &&
                 (^{shreg_q[42:35], par_q[0]}) && (^{shreg_q[34:24], par_q[1]}) &&
                 (^{shreg_q[23:21], par_q[2]}) && (^{shreg_q[20:8], par_q[3]});
  end
`else
  logic unused_b_bit;
  assign unused_b_bit = bits_data_i[1];

  always_comb begin
    frame_good = (second_q == 6'd59) && (shreg_q[7:0] == Marker);
  end
`endif

  assign second_next = second_q + 6'd1;

  always_comb begin
    state_d       = state_q;
    second_d      = second_q;
    shreg_d       = shreg_q;
    tcount_d      = tcount_q;
    fields_d      = fields_q;
    frame_valid_d = 1'b0;
    frame_error_d = 1'b0;
`ifdef MSF_PARITY_CHECK_EN
    par_d         = par_q;
`endif
    unique case (state_q)
      StHunt: begin
        tcount_d = 8'd0;
        if (bits_valid_i && bits_is_second_00_i) begin
          state_d  = StRun;
          second_d = 6'd0;
          shreg_d  = '0;
`ifdef MSF_PARITY_CHECK_EN
          par_d    = '0;
`endif
        end
      end
      StRun: begin
        if (bits_valid_i) begin
          // A decoded boundary always wins over a coincident terminal count.
          tcount_d = 8'd0;
          if (bits_is_second_00_i) begin
            if (frame_good) begin
              fields_d      = shreg_q[42:8];
              frame_valid_d = 1'b1;
            end else begin
              frame_error_d = 1'b1;
            end
            second_d = 6'd0;
            shreg_d  = '0;
`ifdef MSF_PARITY_CHECK_EN
            par_d    = '0;
`endif
          end else if (second_next == 6'd61) begin
            frame_error_d = 1'b1;
            state_d       = StHunt;
            second_d      = 6'd0;
          end else begin
            second_d = second_next;
            if (second_next >= 6'd17 && second_next <= 6'd59) begin
              shreg_d = {shreg_q[41:0], bits_data_i[0]};
            end
`ifdef MSF_PARITY_CHECK_EN
            case (second_next)
              6'd54:   par_d[0] = bits_data_i[1];
              6'd55:   par_d[1] = bits_data_i[1];
              6'd56:   par_d[2] = bits_data_i[1];
              6'd57:   par_d[3] = bits_data_i[1];
              default: ;
            endcase
`endif
          end
        end else if (sample_valid_i) begin
          if (tcount_q == TimeoutLast) begin
            frame_error_d = 1'b1;
            state_d       = StHunt;
            second_d      = 6'd0;
            tcount_d      = 8'd0;
          end else begin
            tcount_d = tcount_q + 8'd1;
          end
        end
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= StHunt;
      second_q      <= 6'd0;
      shreg_q       <= '0;
      tcount_q      <= 8'd0;
      fields_q      <= '0;
      frame_valid_q <= 1'b0;
      frame_error_q <= 1'b0;
`ifdef MSF_PARITY_CHECK_EN
      par_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      second_q      <= second_d;
      shreg_q       <= shreg_d;
      tcount_q      <= tcount_d;
      fields_q      <= fields_d;
      frame_valid_q <= frame_valid_d;
      frame_error_q <= frame_error_d;
`ifdef MSF_PARITY_CHECK_EN
      par_q         <= par_d;
`endif
    end
  end

  assign sync_o        = (state_q == StRun);
  assign second_o      = second_q;
  assign frame_valid_o = frame_valid_q;
  assign frame_error_o = frame_error_q;
  assign year_o        = fields_q[34:27];
  assign month_o       = fields_q[26:22];
  assign day_o         = fields_q[21:16];
  assign dow_o         = fields_q[15:13];
  assign hour_o        = fields_q[12:7];
  assign minute_o      = fields_q[6:0];

endmodule

// File: tb/tb_msf_frame_sequencer.sv
// Self-checking bench for msf_frame_sequencer: frames are built second-by-second from field values
// and the expected verdict is derived from the second-numbered bit arrays.
module tb_msf_frame_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sample_valid = 1'b0;
  logic       bits_valid = 1'b0;
  logic       bits_00 = 1'b0;
  logic [1:0] bits_data = 2'b00;
  logic       sync;
  logic [5:0] second;
  logic       fv, fe;
  logic [7:0] year;
  logic [4:0] month;
  logic [5:0] day;
  logic [2:0] dow;
  logic [5:0] hour;
  logic [6:0] minute;

  msf_frame_sequencer #(.SAMPLES_PER_SEC(10), .TIMEOUT_SAMPLES(15)) dut (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(sample_valid), .bits_valid_i(bits_valid),
    .bits_is_second_00_i(bits_00), .bits_data_i(bits_data), .sync_o(sync), .second_o(second),
    .frame_valid_o(fv), .frame_error_o(fe), .year_o(year), .month_o(month), .day_o(day),
    .dow_o(dow), .hour_o(hour), .minute_o(minute)
  );

  always #5 clk = ~clk;

  int          ncmp = 0;
  int          nfail = 0;
  logic        fa [61];
  logic        fb [61];
  logic [34:0] exp_fields = '0;
  logic [34:0] act_fields;

  assign act_fields = {year, month, day, dow, hour, minute};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One decoded second, preceded by a few idle sampler strobes.
  task automatic send(input logic a, input logic b, input logic is00);
    int gap = $urandom_range(0, 4);
    for (int i = 0; i < gap; i++) begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
    end
    bits_valid = 1'b1;
    bits_00    = is00;
    bits_data  = {b, a};
    tick();
    bits_valid = 1'b0;
    bits_00    = 1'b0;
    bits_data  = 2'b00;
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int s = lo; s <= hi; s++) send(fa[s], fb[s], 1'b0);
  endtask

  task automatic run_minute(input int len);
    run_range(1, len);
    send(1'b0, 1'b0, 1'b1);
  endtask

  // Lay out one minute: fields MSB-first at their seconds, marker, odd-parity B bits.
  task automatic build(input logic [34:0] f);
    logic [7:0] yr = f[34:27];
    logic [4:0] mo = f[26:22];
    logic [5:0] dy = f[21:16];
    logic [2:0] dw = f[15:13];
    logic [5:0] hr = f[12:7];
    logic [6:0] mi = f[6:0];
    logic [7:0] mk = 8'b0111_1110;
    for (int s = 0; s < 61; s++) begin
      fa[s] = 1'($urandom_range(0, 1));
      fb[s] = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < 8; i++) fa[17 + i] = yr[7 - i];
    for (int i = 0; i < 5; i++) fa[25 + i] = mo[4 - i];
    for (int i = 0; i < 6; i++) fa[30 + i] = dy[5 - i];
    for (int i = 0; i < 3; i++) fa[36 + i] = dw[2 - i];
    for (int i = 0; i < 6; i++) fa[39 + i] = hr[5 - i];
    for (int i = 0; i < 7; i++) fa[45 + i] = mi[6 - i];
    for (int i = 0; i < 8; i++) fa[52 + i] = mk[7 - i];
    fb[54] = ~(^yr);
    fb[55] = ~(^{mo, dy});
    fb[56] = ~(^dw);
    fb[57] = ~(^{hr, mi});
  endtask

  function automatic logic model_good(input int len);
    logic [7:0] mk;
    logic       ok;
    for (int i = 0; i < 8; i++) mk[7 - i] = fa[52 + i];
    ok = (len == 59) && (mk == 8'b0111_1110);
`ifdef MSF_PARITY_CHECK_EN
    begin
      logic p0 = fb[54], p1 = fb[55], p2 = fb[56], p3 = fb[57];
      for (int s = 17; s <= 24; s++) p0 ^= fa[s];
      for (int s = 25; s <= 35; s++) p1 ^= fa[s];
      for (int s = 36; s <= 38; s++) p2 ^= fa[s];
      for (int s = 39; s <= 51; s++) p3 ^= fa[s];
      ok = ok && p0 && p1 && p2 && p3;
    end
`endif
    return ok;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    ncmp++; if ({sync, second} !== 7'd0) begin nfail++; $display("FAIL reset_sync_sec got %0h want 0", {sync, second}); end
    ncmp++; if ({fv, fe} !== 2'b00) begin nfail++; $display("FAIL reset_pulses got %0b want 00", {fv, fe}); end
    ncmp++; if (act_fields !== 35'd0) begin nfail++; $display("FAIL reset_fields got %0h want 0", act_fields); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_good_frame();
    logic [34:0] f = {8'h24, 5'h03, 6'h15, 3'd5, 6'h13, 7'h47};
    repeat (3) send(1'b1, 1'b1, 1'b0);
    ncmp++; if ({sync, second} !== 7'd0) begin nfail++; $display("FAIL hunt_ignore got %0h want 0", {sync, second}); end
    send(1'b0, 1'b0, 1'b1);
    ncmp++; if ({sync, second} !== {1'b1, 6'd0}) begin nfail++; $display("FAIL hunt_to_run got %0h want 40", {sync, second}); end
    build(f);
    run_range(1, 30);
    ncmp++; if (second !== 6'd30) begin nfail++; $display("FAIL second_30 got %0d want 30", second); end
    run_range(31, 59);
    ncmp++; if (second !== 6'd59) begin nfail++; $display("FAIL second_59 got %0d want 59", second); end
    send(1'b0, 1'b0, 1'b1);
    ncmp++; if ({fv, fe} !== 2'b10) begin nfail++; $display("FAIL good_pulses got %0b want 10", {fv, fe}); end
    ncmp++; if (act_fields !== f) begin nfail++; $display("FAIL good_fields got %0h want %0h", act_fields, f); end
    ncmp++; if ({sync, second} !== {1'b1, 6'd0}) begin nfail++; $display("FAIL good_sync got %0h want 40", {sync, second}); end
    exp_fields = f;
    tick();
    ncmp++; if ({fv, fe} !== 2'b00) begin nfail++; $display("FAIL good_one_cycle got %0b want 00", {fv, fe}); end
  endtask

  task automatic test_marker_error();
    build({8'h24, 5'h03, 6'h15, 3'd5, 6'h13, 7'h47});
    fa[55] = ~fa[55];
    run_minute(59);
    ncmp++; if ({fv, fe} !== 2'b01) begin nfail++; $display("FAIL marker_pulses got %0b want 01", {fv, fe}); end
    ncmp++; if (act_fields !== exp_fields) begin nfail++; $display("FAIL marker_fields got %0h want %0h", act_fields, exp_fields); end
    ncmp++; if ({sync, second} !== {1'b1, 6'd0}) begin nfail++; $display("FAIL marker_sync got %0h want 40", {sync, second}); end
    tick();
    ncmp++; if (fe !== 1'b0) begin nfail++; $display("FAIL marker_one_cycle got %0b want 0", fe); end
  endtask

  task automatic test_short_minute();
    logic [34:0] f;
    build(35'($urandom()) ^ {3'b0, 32'($urandom())});
    run_minute(58);
    ncmp++; if ({fv, fe} !== 2'b01) begin nfail++; $display("FAIL short_pulses got %0b want 01", {fv, fe}); end
    f = {3'($urandom()), 32'($urandom())};
    build(f);
    run_minute(59);
    ncmp++; if ({fv, fe} !== 2'b10) begin nfail++; $display("FAIL short_recover got %0b want 10", {fv, fe}); end
    exp_fields = f;
    ncmp++; if (act_fields !== exp_fields) begin nfail++; $display("FAIL short_fields got %0h want %0h", act_fields, exp_fields); end
  endtask

  task automatic test_random_frames();
    for (int n = 0; n < 10; n++) begin
      logic [34:0] f = {3'($urandom()), 32'($urandom())};
      int          len = 59;
      int          mode = $urandom_range(0, 5);
      logic        good;
      build(f);
      case (mode)
        0: len = 58;
        1: len = 60;
        2: begin int s = $urandom_range(52, 59); fa[s] = ~fa[s]; end
        3: begin int s = $urandom_range(54, 57); fb[s] = ~fb[s]; end
        default: ;
      endcase
      good = model_good(len);
      if (good) exp_fields = f;
      run_minute(len);
      ncmp++; if ({fv, fe} !== {good, ~good}) begin nfail++; $display("FAIL rand%0d_pulses mode %0d got %0b want %0b", n, mode, {fv, fe}, {good, ~good}); end
      ncmp++; if (act_fields !== exp_fields) begin nfail++; $display("FAIL rand%0d_fields got %0h want %0h", n, act_fields, exp_fields); end
      ncmp++; if ({sync, second} !== {1'b1, 6'd0}) begin nfail++; $display("FAIL rand%0d_sync got %0h want 40", n, {sync, second}); end
    end
  endtask

  task automatic test_overrun();
    build({3'($urandom()), 32'($urandom())});
    run_range(1, 60);
    ncmp++; if ({sync, second} !== {1'b1, 6'd60}) begin nfail++; $display("FAIL leap_second got %0h want 7c", {sync, second}); end
    send(1'b0, 1'b0, 1'b0);
    ncmp++; if ({fv, fe} !== 2'b01) begin nfail++; $display("FAIL overrun_pulses got %0b want 01", {fv, fe}); end
    ncmp++; if ({sync, second} !== 7'd0) begin nfail++; $display("FAIL overrun_hunt got %0h want 0", {sync, second}); end
    ncmp++; if (act_fields !== exp_fields) begin nfail++; $display("FAIL overrun_fields got %0h want %0h", act_fields, exp_fields); end
  endtask

  task automatic test_timeout();
    send(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 14; i++) begin sample_valid = 1'b1; tick(); end
    sample_valid = 1'b0;
    ncmp++; if ({sync, fe} !== 2'b10) begin nfail++; $display("FAIL pre_timeout got %0b want 10", {sync, fe}); end
    sample_valid = 1'b1; bits_valid = 1'b1;
    tick();
    sample_valid = 1'b0; bits_valid = 1'b0;
    ncmp++; if ({sync, fe, second} !== {2'b10, 6'd1}) begin nfail++; $display("FAIL coincident_bits got %0h want 81", {sync, fe, second}); end
    for (int i = 0; i < 14; i++) begin sample_valid = 1'b1; tick(); end
    ncmp++; if ({sync, fe} !== 2'b10) begin nfail++; $display("FAIL timeout_14 got %0b want 10", {sync, fe}); end
    tick();
    sample_valid = 1'b0;
    ncmp++; if ({sync, fe, second} !== {2'b01, 6'd0}) begin nfail++; $display("FAIL timeout_15 got %0h want 40", {sync, fe, second}); end
    send(1'b1, 1'b0, 1'b0);
    ncmp++; if ({sync, fe, fv, second} !== 9'd0) begin nfail++; $display("FAIL post_timeout got %0h want 0", {sync, fe, fv, second}); end
  endtask

  task automatic test_parity57();
    logic [34:0] f = {3'($urandom()), 32'($urandom())};
    logic        good;
    send(1'b0, 1'b0, 1'b1);
    build(f);
    fb[57] = ~fb[57];
    good = model_good(59);
    if (good) exp_fields = f;
    run_minute(59);
    ncmp++; if ({fv, fe} !== {good, ~good}) begin nfail++; $display("FAIL parity57 got %0b want %0b", {fv, fe}, {good, ~good}); end
    ncmp++; if (act_fields !== exp_fields) begin nfail++; $display("FAIL parity57_fields got %0h want %0h", act_fields, exp_fields); end
  endtask

  task automatic test_async_reset();
    build({3'($urandom()), 32'($urandom())});
    run_range(1, 30);
    ncmp++; if ({sync, second} !== {1'b1, 6'd30}) begin nfail++; $display("FAIL mid_run got %0h want 5e", {sync, second}); end
    #2;
    rst = 1'b1;
    #1;
    ncmp++; if ({sync, second, fv, fe} !== 9'd0) begin nfail++; $display("FAIL async_reset_ctl got %0h want 0", {sync, second, fv, fe}); end
    ncmp++; if (act_fields !== 35'd0) begin nfail++; $display("FAIL async_reset_fields got %0h want 0", act_fields); end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_marker_error();
    test_short_minute();
    test_random_frames();
    test_overrun();
    test_timeout();
    test_parity57();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
